bar_rr_arbiter: RTL and testbench
=================================

# bar_rr_arbiter

Round-robin arbiter that shares a single `bar` output channel between N `bar` input channels. Each requester presents 32-bit words through a `bar.in` modport. The arbiter picks one valid requester per cycle, accepts its word into a single output register, and drives it out through a `bar.out` modport with valid/ready flow control. It sits between multiple producer modules and one consumer, for example in front of a shared FIFO or bus port.

## Interface
- `N`, default 4: number of requesters, legal range 2..16.
- `IW`, default `$clog2(N)`: width of the source index; derived, not overridden.

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `s[N]`  interface  `bar.in`  requester channels. `data`/`valid` are inputs; `ready` is an output.
- `m`  interface  `bar.out`  shared output channel. `data`/`valid` are outputs; `ready` is an input.
- `mask`  input  N  per-requester enable. A 0 bit means that requester is never granted and its `ready` is held at 0.
- `m_src`  output  IW  index of the requester whose word currently sits in the output register.

## Operation
- Output register holds `m.data`, `m.valid` and `m_src`.
- Full flag `F` is `m.valid`.
- Accept condition: `acc = !F || m.ready`.
- Eligible vector: `e[i] = s[i].valid && mask[i]`.
- Round-robin pointer `ptr` (IW bits) points to the highest-priority requester.
- Winner `win` is the first `i` with `e[i]=1`, searching `ptr, ptr+1, …, N-1, 0, …, ptr-1`. This is combinational.
- `s[i].ready = acc && (e != 0) && (i == win)`. This is combinational, so `ready` depends on `m.ready` in the same cycle. At most one `s[i].ready` is high in any cycle.
- On a clock edge with `acc && e != 0`:
  - `m.data <= s[win].data`, `m.valid <= 1`, `m_src <= win`.
  - `ptr <= (win == N-1) ? 0 : win+1`.
- On a clock edge with `acc && e == 0`:
  - `m.valid <= 0`.
  - `m.data`, `m_src` and `ptr` are unchanged.
- On a clock edge with `!acc`: all state is unchanged (stall).
- Output stability: while `m.valid && !m.ready`, `m.data` and `m_src` are held bit-stable.
- The arbiter never drops a word once `m.valid=1`.
- No state machine beyond the full flag and `ptr`. The two effective states are EMPTY (`F=0`) and FULL (`F=1`):
  - EMPTY → FULL when `e != 0`.
  - FULL → EMPTY when `m.ready && e == 0`.
  - FULL → FULL on a stall, or on `m.ready && e != 0` (back-to-back transfer).
- Index arithmetic uses IW bits. `N` that is not a power of two wraps explicitly at N-1, never by overflow.
- Changing `mask` takes effect in the same cycle's arbitration. It does not affect a word already in the output register.

## Timing
- Reset: when `rst_n=0` at a rising edge:
  - `m.valid=0`, `m.data=32'h0`, `m_src=0`, `ptr=0`.
  - All `s[i].ready` evaluate to 0 while the reset state is empty and `rst_n=0`. `ready` is gated by `rst_n`.
- Latency: a word accepted at edge k appears on `m.data`/`m.valid` after edge k, i.e. 1 cycle.
- Throughput: one word per cycle when `m.ready=1` continuously.
- With all requesters continuously valid and unmasked, grants rotate in strict order: 0, 1, …, N-1, 0, …
- Worst-case wait for a continuously valid, unmasked requester is N-1 grants to others.
- Simultaneous drain and fill (`F=1`, `m.ready=1`, `e != 0`): both happen at the same edge and there is no bubble.
- Reset mid-transfer: the word in the output register is discarded, `ptr` returns to 0, and no `s[i].ready` is asserted during that cycle.
- A requester dropping `valid` without a handshake is legal. It only changes the winner for that cycle.

## Test plan
- Reset values: hold `rst_n=0` for 2 cycles with all `s[i].valid=1` → `m.valid=0`, `m.data=0`, `m_src=0`, all `s[i].ready=0`. Release reset → first grant goes to requester 0.
- Single requester: only `s[2]` valid with data 32'hA5A5_0001…0004, `m.ready=1` → 4 consecutive outputs in order, one cycle after each accept, `m_src=2`, then `ptr=3`.
- Fairness: all 4 requesters valid, each with a unique tag, `m.ready=1` for 12 cycles → `m_src` sequence 0,1,2,3,0,1,2,3,0,1,2,3 with no bubbles.
- Backpressure: output register full with 32'hDEAD_BEEF, then `m.ready=0` for 5 cycles → `m.data`/`m_src` stable and all `s[i].ready=0`. Raising `m.ready` accepts the next word at the same edge.
- Masking: all valid, `mask=4'b1010` → grants alternate 1,3,1,3 and `s[0].ready`/`s[2].ready` never go high. Clearing `mask` to 0 with the register full → the pending word still drains, then `m.valid=0`.
- Reset mid-stream: apply `rst_n=0` while `m.valid=1` and `ptr=2` → the next cycle shows `m.valid=0` and `ptr=0`. After release, grant order restarts at 0.

Source files
------------

// File: rtl/bar_rr_arbiter_if.sv
// 32-bit valid/ready channel shared by every requester and the output of bar_rr_arbiter.
interface bar;
  logic [31:0] data;
  logic        valid;
  logic        ready;

  modport in  (input  data, input  valid, output ready);
  modport out (output data, output valid, input  ready);
endinterface

// File: rtl/bar_rr_arbiter.sv
// Round-robin arbiter: N bar requesters share one registered bar output channel.
// One word is accepted per cycle; the pointer moves past each winner so grants rotate fairly.
module bar_rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  bar.in                s [N],
  bar.out               m,
  input  logic [N-1:0]  mask,
  output logic [IW-1:0] m_src
);

  logic [31:0]   s_data [N];
  logic [N-1:0]  s_valid;
  logic [N-1:0]  s_ready;

  logic          full_q, full_d;
  logic [31:0]   data_q, data_d;
  logic [IW-1:0] src_q, src_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [N-1:0]  elig;
  logic          any_e;
  logic          acc;
  logic [IW-1:0] win;

  // Interface arrays only allow constant indices, so flatten them here.
  for (genvar i = 0; i < N; i++) begin : g_ch
    assign s_data[i]  = s[i].data;
    assign s_valid[i] = s[i].valid;
    assign s[i].ready = s_ready[i];
  end

  assign elig = s_valid & mask;
  assign acc  = !full_q || m.ready;

  // Search ptr, ptr+1, ... with an explicit wrap so non power-of-two N works.
  always_comb begin
    int idx;
    win   = '0;
    any_e = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!any_e && elig[idx]) begin
        any_e = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_comb begin
    s_ready = '0;
    if (rst_n && acc && any_e) s_ready[win] = 1'b1;
  end

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    src_d  = src_q;
    ptr_d  = ptr_q;
    if (acc) begin
      if (any_e) begin
        full_d = 1'b1;
        data_d = s_data[win];
        src_d  = win;
        ptr_d  = (win == IW'(N - 1)) ? '0 : win + IW'(1);
      end else begin
        full_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= 32'h0;
      src_q  <= '0;
      ptr_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      src_q  <= src_d;
      ptr_q  <= ptr_d;
    end
  end

  assign m.data  = data_q;
  assign m.valid = full_q;
  assign m_src   = src_q;

endmodule

// File: tb/tb_bar_rr_arbiter.sv
// Directed self-checking bench for bar_rr_arbiter with N=4.
module tb_bar_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  mask;
  logic [1:0]  m_src;
  logic        m_ready;
  logic [31:0] s_data [4];
  logic [3:0]  s_valid;
  logic [3:0]  s_ready;

  int checks = 0;
  int errors = 0;

  bar s_if [4] ();
  bar m_if ();

  for (genvar g = 0; g < 4; g++) begin : g_drv
    assign s_if[g].data  = s_data[g];
    assign s_if[g].valid = s_valid[g];
    assign s_ready[g]    = s_if[g].ready;
  end
  assign m_if.ready = m_ready;

  bar_rr_arbiter #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (s_if),
    .m     (m_if),
    .mask  (mask),
    .m_src (m_src)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = 4'b0000;
    mask    = 4'b1111;
    m_ready = 1'b1;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    mask    = 4'b1111;
    m_ready = 1'b1;
    s_valid = 4'b1111;
    for (int i = 0; i < 4; i++) s_data[i] = 32'h1000_0000 + i;
    step();
    step();
    #1;
    checks++; if (m_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", m_if.valid); end
    checks++; if (m_if.data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", m_if.data); end
    checks++; if (m_src !== 2'd0) begin errors++; $display("FAIL reset_src got %0d want 0", m_src); end
    checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", s_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (s_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_ready got %b want 0001", s_ready); end
    step();
    checks++; if (m_if.valid !== 1'b1 || m_src !== 2'd0 || m_if.data !== 32'h1000_0000) begin
      errors++; $display("FAIL reset_first_grant got v=%b src=%0d data=%h want v=1 src=0 data=10000000", m_if.valid, m_src, m_if.data);
    end
    s_valid = 4'b0000;
    step();
  endtask

  task automatic test_single();
    do_reset();
    s_valid = 4'b0100;
    for (int w = 0; w < 4; w++) begin
      s_data[2] = 32'hA5A5_0001 + w;
      #1;
      checks++; if (s_ready !== 4'b0100) begin errors++; $display("FAIL single_ready[%0d] got %b want 0100", w, s_ready); end
      step();
      checks++; if (m_if.valid !== 1'b1 || m_src !== 2'd2 || m_if.data !== 32'hA5A5_0001 + w) begin
        errors++; $display("FAIL single_out[%0d] got v=%b src=%0d data=%h want v=1 src=2 data=%h", w, m_if.valid, m_src, m_if.data, 32'hA5A5_0001 + w);
      end
    end
    s_valid = 4'b0000;
    checks++; if (dut.ptr_q !== 2'd3) begin errors++; $display("FAIL single_ptr got %0d want 3", dut.ptr_q); end
    step();
    checks++; if (m_if.valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", m_if.valid); end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < 4; i++) s_data[i] = 32'hC0DE_0000 + i;
    s_valid = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      #1;
      checks++; if (s_ready !== 4'b0001 << (k % 4)) begin errors++; $display("FAIL fair_ready[%0d] got %b want %b", k, s_ready, 4'b0001 << (k % 4)); end
      step();
      checks++; if (m_if.valid !== 1'b1 || m_src !== 2'(k % 4) || m_if.data !== 32'hC0DE_0000 + (k % 4)) begin
        errors++; $display("FAIL fair_out[%0d] got v=%b src=%0d data=%h want src=%0d", k, m_if.valid, m_src, m_if.data, k % 4);
      end
    end
    s_valid = 4'b0000;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    s_data[0] = 32'hDEAD_BEEF;
    s_valid   = 4'b0001;
    step();
    m_ready = 1'b0;
    s_valid = 4'b1111;
    for (int i = 0; i < 4; i++) s_data[i] = 32'h1111_0000 + i;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0000", c, s_ready); end
      step();
      checks++; if (m_if.valid !== 1'b1 || m_src !== 2'd0 || m_if.data !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b src=%0d data=%h want v=1 src=0 data=deadbeef", c, m_if.valid, m_src, m_if.data);
      end
    end
    m_ready = 1'b1;
    #1;
    checks++; if (s_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got %b want 0010", s_ready); end
    step();
    checks++; if (m_src !== 2'd1 || m_if.data !== 32'h1111_0001) begin
      errors++; $display("FAIL bp_release_out got src=%0d data=%h want src=1 data=11110001", m_src, m_if.data);
    end
    s_valid = 4'b0000;
    step();
  endtask

  task automatic test_masking();
    logic [3:0] exp_ready;
    logic [1:0] exp_src;
    do_reset();
    for (int i = 0; i < 4; i++) s_data[i] = 32'hBEE0_0000 + i;
    s_valid = 4'b1111;
    mask    = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      exp_ready = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      exp_src   = (k % 2 == 0) ? 2'd1 : 2'd3;
      #1;
      checks++; if (s_ready !== exp_ready) begin errors++; $display("FAIL mask_ready[%0d] got %b want %b", k, s_ready, exp_ready); end
      step();
      checks++; if (m_src !== exp_src || m_if.data !== 32'hBEE0_0000 + exp_src) begin
        errors++; $display("FAIL mask_out[%0d] got src=%0d data=%h want src=%0d", k, m_src, m_if.data, exp_src);
      end
    end
    mask    = 4'b0000;
    m_ready = 1'b0;
    #1;
    checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL mask_zero_ready got %b want 0000", s_ready); end
    step();
    checks++; if (m_if.valid !== 1'b1 || m_src !== 2'd3 || m_if.data !== 32'hBEE0_0003) begin
      errors++; $display("FAIL mask_pending got v=%b src=%0d data=%h want v=1 src=3 data=bee00003", m_if.valid, m_src, m_if.data);
    end
    m_ready = 1'b1;
    step();
    checks++; if (m_if.valid !== 1'b0) begin errors++; $display("FAIL mask_drain got %b want 0", m_if.valid); end
    s_valid = 4'b0000;
    mask    = 4'b1111;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 4; i++) s_data[i] = 32'h7700_0000 + i;
    s_valid = 4'b1111;
    step();
    step();
    checks++; if (m_if.valid !== 1'b1 || m_src !== 2'd1 || dut.ptr_q !== 2'd2) begin
      errors++; $display("FAIL midrst_pre got v=%b src=%0d ptr=%0d want v=1 src=1 ptr=2", m_if.valid, m_src, dut.ptr_q);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ready got %b want 0000", s_ready); end
    step();
    checks++; if (m_if.valid !== 1'b0 || dut.ptr_q !== 2'd0 || m_if.data !== 32'h0) begin
      errors++; $display("FAIL midrst_state got v=%b ptr=%0d data=%h want v=0 ptr=0 data=0", m_if.valid, dut.ptr_q, m_if.data);
    end
    rst_n = 1'b1;
    #1;
    checks++; if (s_ready !== 4'b0001) begin errors++; $display("FAIL midrst_restart_ready got %b want 0001", s_ready); end
    step();
    checks++; if (m_src !== 2'd0 || m_if.data !== 32'h7700_0000) begin
      errors++; $display("FAIL midrst_restart got src=%0d data=%h want src=0 data=77000000", m_src, m_if.data);
    end
    s_valid = 4'b0000;
  endtask

  initial begin
    rst_n   = 1'b0;
    mask    = 4'b1111;
    m_ready = 1'b1;
    s_valid = 4'b0000;
    for (int i = 0; i < 4; i++) s_data[i] = 32'h0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_masking();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
